alu_arbiter: RTL

- Sequencer and two-port round-robin arbiter that shares one 4-bit ALU datapath between two requesters (e.g. button-driven lab front end and a self-test pattern generator).
- Latches the winning requester's opcode and operands, runs one ALU evaluation, and registers the result and flags.
- Returns the result tagged with the requester id, and drives the board LED word (active-low) from the last result.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and sequencer state encoding for the
// two-requester ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUBA = 3'b010;
  localparam logic [2:0] OP_SUBB = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // Bit positions inside the 4-bit {cf, ovf, zf, nf} flag word
  localparam int FLG_CF  = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_ZF  = 1;
  localparam int FLG_NF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU: eight operations, carry/borrow, signed overflow,
// zero and negative flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         cf,
  output logic         ovf,
  output logic         zf,
  output logic         nf
);

  logic [W:0] t;

  always_comb begin
    t   = '0;
    y   = a;
    cf  = 1'b0;
    ovf = 1'b0;
    case (op)
      OP_PASS: y = a;
      OP_ADD: begin
        t   = {1'b0, a} + {1'b0, b};
        y   = t[W-1:0];
        cf  = t[W];
        ovf = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      // Zero-extended subtraction: the extra top bit is the borrow
      OP_SUBA: begin
        t   = {1'b0, a} - {1'b0, b};
        y   = t[W-1:0];
        cf  = t[W];
        ovf = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      OP_SUBB: begin
        t   = {1'b0, b} - {1'b0, a};
        y   = t[W-1:0];
        cf  = t[W];
        ovf = (b[W-1] != a[W-1]) && (y[W-1] != b[W-1]);
      end
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a;
    endcase
  end

  assign zf = (y == '0);
  assign nf = y[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters; registers the
// tagged result, flags, an operation counter and an active-low LED word.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [W-1:0]     res_y,
  output logic [3:0]       res_flags,
  output logic [CNT_W-1:0] ops_done,
  output logic [W+3:0]     led
);

  // Handshake: a requester raises reqN with opN/aN/bN stable and holds them
  // until the one-cycle gntN pulse; the operands are latched on the edge that
  // raises gntN. Requests are only sampled in IDLE, so a req still high when
  // the sequencer returns to IDLE counts as a fresh request.
  state_t         state, state_nxt;
  logic           last_id;
  logic           id_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic           any_req, win_id;
  logic [W-1:0]   alu_y;
  logic           alu_cf, alu_ovf, alu_zf, alu_nf;
  logic [3:0]     alu_flags;

  assign any_req = req0 | req1;
  assign win_id  = (req0 && req1) ? ~last_id : req1;

  alu_core #(.W(W)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (alu_y),
    .cf  (alu_cf),
    .ovf (alu_ovf),
    .zf  (alu_zf),
    .nf  (alu_nf)
  );

  always_comb begin
    alu_flags          = '0;
    alu_flags[FLG_CF]  = alu_cf;
    alu_flags[FLG_OVF] = alu_ovf;
    alu_flags[FLG_ZF]  = alu_zf;
    alu_flags[FLG_NF]  = alu_nf;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // last_id resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_y     <= '0;
      res_flags <= '0;
      ops_done  <= '0;
      led       <= '1;
      last_id   <= 1'b1;
      id_q      <= 1'b0;
      op_q      <= OP_PASS;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            id_q    <= win_id;
            last_id <= win_id;
            op_q    <= win_id ? op1 : op0;
            a_q     <= win_id ? a1 : a0;
            b_q     <= win_id ? b1 : b0;
            gnt0    <= ~win_id;
            gnt1    <= win_id;
          end
        end
        ST_EXEC: begin
          res_y     <= alu_y;
          res_flags <= alu_flags;
          res_id    <= id_q;
          led       <= ~{alu_flags, alu_y};
          res_valid <= 1'b1;
          ops_done  <= ops_done + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
